// File: rtl/gactx_pkg.sv
// Shared types and helpers for the GACTX read scheduler.
package gactx_pkg;

  typedef enum logic [2:0] {IDLE, START, XFER, DONE, ZERO} sched_state_t;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gactx_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after the pointer.
module gactx_rr_arbiter
  import gactx_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [GRANT_W-1:0] ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [GRANT_W-1:0] grant_idx
);

  always_comb begin
    int cand;
    cand         = 0;
    any          = 1'b0;
    grant_onehot = '0;
    grant_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!any && eligible[cand]) begin
        any                = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = GRANT_W'(cand);
      end
    end
  end

endmodule

// File: rtl/gactx_read_scheduler.sv
// Shares one AXI4 read master among NUM_REQ requesters: round-robin grant,
// command programming, stream steering and completion pulses.
module gactx_read_scheduler
  import gactx_pkg::*;
#(
  parameter int NUM_REQ            = 2,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_AXIS_TDATA_WIDTH = 512,
  localparam int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic                                    aclk,
  input  logic                                    areset_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*C_XFER_SIZE_WIDTH-1:0]    req_bytes,
  output logic [NUM_REQ-1:0]                      req_done,
  output logic                                    rd_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]           rd_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]            rd_bytes,
  input  logic                                    rd_done,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  logic                                    s_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]           s_axis_tdata,
  output logic [NUM_REQ-1:0]                      m_axis_tvalid,
  input  logic [NUM_REQ-1:0]                      m_axis_tready,
  output logic [NUM_REQ-1:0]                      m_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                    busy,
  output logic [GRANT_W-1:0]                      grant_id
);

  sched_state_t state_reg, state_next;
  logic [GRANT_W-1:0]           grant_reg;
  logic [NUM_REQ-1:0]           grant_oh_reg;
  logic [GRANT_W-1:0]           ptr_reg;
  logic                         done_seen_reg;
  logic                         last_seen_reg;

  logic [NUM_REQ-1:0]           eligible;
  logic                         arb_any;
  logic [NUM_REQ-1:0]           arb_onehot;
  logic [GRANT_W-1:0]           arb_idx;
  logic [C_M_AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]  sel_bytes;
  logic                         in_xfer;
  logic                         beat_last;

  // A requester whose done pulse is on the wire is not yet allowed to re-win.
  assign eligible = req_valid & ~req_done;

  gactx_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .eligible     (eligible),
    .ptr          (ptr_reg),
    .any          (arb_any),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx)
  );

  assign sel_addr  = req_addr[int'(arb_idx)*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
  assign sel_bytes = req_bytes[int'(arb_idx)*C_XFER_SIZE_WIDTH +: C_XFER_SIZE_WIDTH];

  assign in_xfer       = (state_reg == XFER);
  assign rd_start      = (state_reg == START);
  assign busy          = (state_reg != IDLE);
  assign grant_id      = grant_reg;
  assign s_axis_tready = in_xfer & |(m_axis_tready & grant_oh_reg);
  assign m_axis_tdata  = in_xfer ? s_axis_tdata : '0;
  assign beat_last     = s_axis_tvalid & s_axis_tready & s_axis_tlast;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign m_axis_tvalid[gi] = in_xfer & grant_oh_reg[gi] & s_axis_tvalid;
    assign m_axis_tlast[gi]  = in_xfer & grant_oh_reg[gi] & s_axis_tvalid & s_axis_tlast;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (arb_any) state_next = (sel_bytes == '0) ? ZERO : START;
      START: state_next = XFER;
      XFER:  if ((done_seen_reg | rd_done) && (last_seen_reg | beat_last)) state_next = DONE;
      DONE:  state_next = IDLE;
      ZERO:  state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      grant_reg     <= '0;
      grant_oh_reg  <= '0;
      ptr_reg       <= '0;
      done_seen_reg <= 1'b0;
      last_seen_reg <= 1'b0;
      rd_addr       <= '0;
      rd_bytes      <= '0;
      req_done      <= '0;
    end else begin
      req_done <= '0;
      unique case (state_reg)
        IDLE: begin
          if (arb_any) begin
            grant_reg    <= arb_idx;
            grant_oh_reg <= arb_onehot;
            rd_addr      <= sel_addr;
            rd_bytes     <= sel_bytes;
          end
        end
        START: begin
          done_seen_reg <= 1'b0;
          last_seen_reg <= 1'b0;
        end
        XFER: begin
          if (rd_done)   done_seen_reg <= 1'b1;
          if (beat_last) last_seen_reg <= 1'b1;
        end
        DONE: begin
          req_done <= grant_oh_reg;
          ptr_reg  <= (grant_reg == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gactx_read_scheduler.sv
// Directed bench for gactx_read_scheduler: vector table plus hand sequences.
`timescale 1ns/1ps
module tb_gactx_read_scheduler;

  localparam int NR = 2;
  localparam int AW = 64;
  localparam int XW = 32;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            areset_n;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*XW-1:0] req_bytes;
  logic [NR-1:0]   req_done;
  logic            rd_start;
  logic [AW-1:0]   rd_addr;
  logic [XW-1:0]   rd_bytes;
  logic            rd_done;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic [DW-1:0]   s_axis_tdata;
  logic [NR-1:0]   m_axis_tvalid;
  logic [NR-1:0]   m_axis_tready;
  logic [NR-1:0]   m_axis_tlast;
  logic [DW-1:0]   m_axis_tdata;
  logic            busy;
  logic [0:0]      grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gactx_read_scheduler #(
    .NUM_REQ(NR), .C_M_AXI_ADDR_WIDTH(AW), .C_XFER_SIZE_WIDTH(XW), .C_AXIS_TDATA_WIDTH(DW)
  ) dut (
    .aclk(clk), .areset_n(areset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_bytes(req_bytes), .req_done(req_done),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_bytes(rd_bytes), .rd_done(rd_done),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata),
    .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    int          id;
    logic [63:0] addr;
    logic [31:0] bytes;
    int          beats;
    int          dcyc;
    int          exp_done;
  } vec_t;

  vec_t vec [4];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int id, input int k);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(id * 1000 + k);
    return {16{w}};
  endfunction

  task automatic set_req(input int id, input logic [63:0] addr, input logic [31:0] bytes);
    req_addr[id*AW +: AW]  = addr;
    req_bytes[id*XW +: XW] = bytes;
    req_valid[id]          = 1'b1;
  endtask

  // Entered during the cycle in which the request is already eligible.
  // exp_done < 0: expected completion = max(last-beat cycle, rd_done cycle) + 2.
  task automatic do_xfer(input int id, input logic [63:0] addr, input logic [31:0] bytes,
                         input int beats, input int dcyc, input bit bp, input int exp_done);
    int c, sent, lcyc, got;
    bit lane_ok, rdy_ok, data_ok, start_ok;
    logic [NR-1:0] oh;
    oh = NR'(1) << id;
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("start_pulse_r%0d", id), rd_start, 1);
    chk($sformatf("start_addr_r%0d", id), rd_addr, addr);
    chk($sformatf("start_bytes_r%0d", id), rd_bytes, bytes);
    chk($sformatf("start_grant_r%0d", id), grant_id, id);
    chk($sformatf("start_done_low_r%0d", id), req_done, 0);
    sent = 0; lcyc = -1; c = 0;
    lane_ok = 1; rdy_ok = 1; data_ok = 1; start_ok = 1;
    while ((sent < beats || c <= dcyc) && c < 2000) begin
      @(posedge clk); #1;
      s_axis_tvalid = (sent < beats);
      s_axis_tdata  = pat(id, sent);
      s_axis_tlast  = (sent == beats - 1);
      rd_done       = (c == dcyc);
      if (bp) m_axis_tready[id] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rd_start) start_ok = 0;
      if (s_axis_tready !== m_axis_tready[id]) rdy_ok = 0;
      if (m_axis_tvalid !== (s_axis_tvalid ? oh : '0)) lane_ok = 0;
      if (s_axis_tvalid && s_axis_tready) begin
        if (m_axis_tdata !== pat(id, sent) || m_axis_tlast !== (s_axis_tlast ? oh : '0)) data_ok = 0;
        if (s_axis_tlast) lcyc = c;
        sent++;
      end
      c++;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0; rd_done = 0;
    m_axis_tready = '1;
    chk($sformatf("beat_count_r%0d", id), sent, beats);
    chk($sformatf("lane_steer_r%0d", id), lane_ok, 1);
    chk($sformatf("tready_mux_r%0d", id), rdy_ok, 1);
    chk($sformatf("beat_data_r%0d", id), data_ok, 1);
    chk($sformatf("single_start_r%0d", id), start_ok, 1);
    if (exp_done < 0) exp_done = ((lcyc > dcyc) ? lcyc : dcyc) + 2;
    got = -1;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (req_done != '0) begin
        got = c;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    chk($sformatf("done_cycle_r%0d", id), got, exp_done);
    chk($sformatf("done_onehot_r%0d", id), req_done, oh);
    req_valid[id] = 1'b0;
    $display("xfer req%0d addr=%0h bytes=%0d beats=%0d done_cycle=%0d", id, addr, bytes, sent, got);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit stray, early, start_seen;
    vec[0] = '{0, 64'h0000_0012_3456_7000, 32'd4096, 64, 63, 65};
    vec[1] = '{1, 64'h0000_0000_2000_0040, 32'd512, 8, 2, 9};
    vec[2] = '{0, 64'h0000_00AB_CDEF_0000, 32'd512, 8, 12, 14};
    vec[3] = '{1, 64'hFFFF_FFFF_FFFF_FFC0, 32'd64, 1, 0, 2};

    areset_n = 0; req_valid = '0; req_addr = '0; req_bytes = '0; rd_done = 0;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0; m_axis_tready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {rd_start, busy, req_done, grant_id, s_axis_tready}, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_rd_bytes", rd_bytes, 0);
    areset_n = 1;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_req(vec[i].id, vec[i].addr, vec[i].bytes);
      do_xfer(vec[i].id, vec[i].addr, vec[i].bytes, vec[i].beats, vec[i].dcyc, 1'b0, vec[i].exp_done);
    end

    // Simultaneous pair with pointer at 0: 0 then 1.
    @(posedge clk); #1;
    set_req(0, 64'h0000_0000_0000_1000, 32'd64);
    set_req(1, 64'h0000_0000_0000_2000, 32'd64);
    do_xfer(0, 64'h0000_0000_0000_1000, 32'd64, 1, 0, 1'b0, 2);
    do_xfer(1, 64'h0000_0000_0000_2000, 32'd64, 1, 0, 1'b0, 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pair_done_single_pulse", req_done, 0);
    chk("pair_idle", busy, 0);

    // Lone req0 moves the pointer to 1, so the next pair goes 1 then 0.
    @(posedge clk); #1;
    set_req(0, 64'h0000_0000_0000_3000, 32'd128);
    do_xfer(0, 64'h0000_0000_0000_3000, 32'd128, 2, 1, 1'b0, 3);
    @(posedge clk); #1;
    set_req(0, 64'h0000_0000_0000_4000, 32'd64);
    set_req(1, 64'h0000_0000_0000_5000, 32'd64);
    do_xfer(1, 64'h0000_0000_0000_5000, 32'd64, 1, 0, 1'b0, 2);
    do_xfer(0, 64'h0000_0000_0000_4000, 32'd64, 1, 0, 1'b0, 2);

    // Zero-length request with a stray beat and stray rd_done present.
    @(posedge clk); #1;
    set_req(1, 64'h0000_0000_0000_6000, 32'd0);
    s_axis_tvalid = 1; s_axis_tlast = 1; s_axis_tdata = pat(9, 0);
    stray = 0; early = 0; start_seen = 0;
    for (int k = 0; k < 4; k++) begin
      rd_done = (k == 1);
      @(negedge clk);
      if (rd_start) start_seen = 1;
      if (s_axis_tready || m_axis_tvalid != '0 || m_axis_tlast != '0) stray = 1;
      if (k < 3 && req_done != '0) early = 1;
      if (k == 1) chk("zero_grant", grant_id, 1);
      if (k == 3) chk("zero_done", req_done, 2'b10);
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    req_valid[1] = 0; s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0; rd_done = 0;
    chk("zero_no_start", start_seen, 0);
    chk("zero_stream_blocked", stray, 0);
    chk("zero_not_early", early, 0);
    $display("xfer req1 zero-length done_cycle=3");

    // Random backpressure on lane 1; lane 0 stays ready to expose a wrong tready mux.
    @(posedge clk); #1;
    set_req(1, 64'h0000_0000_0000_7000, 32'd1024);
    do_xfer(1, 64'h0000_0000_0000_7000, 32'd1024, 16, 3, 1'b1, -1);

    // Reset asserted mid-transfer, then a fresh request.
    @(posedge clk); #1;
    set_req(0, 64'h0000_0000_0000_8000, 32'd2048);
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_axis_tvalid = 1; s_axis_tdata = pat(0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_reset_lane0", m_axis_tvalid, 2'b01);
    #1;
    areset_n = 0;
    #1;
    chk("async_reset_ctrl", {rd_start, busy, req_done, grant_id, s_axis_tready, m_axis_tvalid, m_axis_tlast}, 0);
    chk("async_reset_rd_addr", rd_addr, 0);
    chk("async_reset_rd_bytes", rd_bytes, 0);
    chk("async_reset_tdata", m_axis_tdata, 0);
    $display("reset asserted mid-transfer");
    req_valid = '0; s_axis_tvalid = 0; s_axis_tdata = '0;
    @(posedge clk); #1;
    areset_n = 1;
    @(posedge clk); #1;
    set_req(1, 64'h0000_0000_0000_9000, 32'd128);
    do_xfer(1, 64'h0000_0000_0000_9000, 32'd128, 2, 1, 1'b0, 3);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
